mmu_seq_counter: RTL and testbench

MMU_SEQ_COUNTER -- requirements
Module: mmu_seq_counter

---
 rtl/mmu_seq_counter.sv | 138 +++++++++++++
 tb/tb_mmu_seq_counter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_seq_counter.sv
// LOAD/RUN/DRAIN phase sequencer with programmable RUN length.
// In: clk rst_n start_i len_i stall_i abort_i; out: state_o cnt_o busy_o run_o done_o err_o.
module mmu_seq_counter #(
  parameter int MAX_LEN   = 64,
  parameter int LOAD_NUM  = 4,
  parameter int DRAIN_NUM = 7,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  localparam int LD_W  = $clog2(LOAD_NUM + 1),
  localparam int DR_W  = $clog2(DRAIN_NUM + 1),
  localparam int MX_W  = (LEN_W > LD_W) ? LEN_W : LD_W,
  localparam int CNT_W = (MX_W > DR_W) ? MX_W : DR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             run_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q;
  state_e           state_d;
  state_e           nxt_ph;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic             err_q;
  logic             err_d;
  logic             len_ok;

  assign len_ok = (len_i != '0) &&
                  (len_i <= LEN_W'(MAX_LEN));

  always_comb begin
    last   = '0;
    nxt_ph = IDLE;
    unique case (state_q)
      LOAD: begin
        last   = CNT_W'(LOAD_NUM - 1);
        nxt_ph = RUN;
      end
      RUN: begin
        last   = CNT_W'(len_q) - CNT_W'(1);
        nxt_ph = DRAIN;
      end
      DRAIN: begin
        last   = CNT_W'(DRAIN_NUM - 1);
        nxt_ph = DONE;
      end
      default: begin
        last   = '0;
        nxt_ph = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          if (len_ok) begin
            state_d = LOAD;
            len_d   = len_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD, RUN, DRAIN: begin
        // abort wins over both stall and phase end
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!stall_i) begin
          if (cnt_q == last) begin
            state_d = nxt_ph;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign busy_o  = (state_q == LOAD) ||
                   (state_q == RUN)  ||
                   (state_q == DRAIN);
  assign run_o   = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_mmu_seq_counter.sv
// Scoreboard bench for mmu_seq_counter.
// Model predicts outputs per edge; queue holds them until sampled.
module tb_mmu_seq_counter;

  localparam int MAX_LEN   = 64;
  localparam int LOAD_NUM  = 4;
  localparam int DRAIN_NUM = 7;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = 7;
  localparam int VW    = 3 + CNT_W + 4;

  typedef logic [VW-1:0] vec_t;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             stall_i;
  logic             abort_i;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cnt_o;
  logic             busy_o;
  logic             run_o;
  logic             done_o;
  logic             err_o;

  mmu_seq_counter #(
    .MAX_LEN  (MAX_LEN),
    .LOAD_NUM (LOAD_NUM),
    .DRAIN_NUM(DRAIN_NUM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .len_i  (len_i),
    .stall_i(stall_i),
    .abort_i(abort_i),
    .state_o(state_o),
    .cnt_o  (cnt_o),
    .busy_o (busy_o),
    .run_o  (run_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  int   m_state;
  int   m_cnt;
  int   m_len;
  bit   m_err;
  int   cyc;
  int   done_cnt;
  int   done_cyc;
  int   run_cnt;
  vec_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic vec_t dut_vec();
    return {state_o, cnt_o, busy_o,
            run_o, done_o, err_o};
  endfunction

  function automatic vec_t mdl_vec();
    logic b;
    b = (m_state >= 1) && (m_state <= 3);
    return {3'(m_state), CNT_W'(m_cnt), b,
            m_state == 2, m_state == 4, m_err};
  endfunction

  function automatic int lim(input int s);
    case (s)
      1: return LOAD_NUM;
      2: return m_len;
      default: return DRAIN_NUM;
    endcase
  endfunction

  task automatic mdl_edge(input bit s, input int l,
                          input bit st, input bit ab);
    m_err = 0;
    case (m_state)
      0: begin
        m_cnt = 0;
        if (s) begin
          if (l >= 1 && l <= MAX_LEN) begin
            m_state = 1;
            m_len = l;
          end else begin
            m_err = 1;
          end
        end
      end
      1, 2, 3: begin
        if (ab) begin
          m_state = 0;
          m_cnt = 0;
        end else if (!st) begin
          if (m_cnt == lim(m_state) - 1) begin
            m_state = m_state + 1;
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      default: begin
        m_state = 0;
        m_cnt = 0;
      end
    endcase
  endtask

  task automatic step(input bit s, input int l,
                      input bit st, input bit ab);
    vec_t e;
    @(negedge clk);
    start_i = s;
    len_i   = LEN_W'(l);
    stall_i = st;
    abort_i = ab;
    @(posedge clk);
    mdl_edge(s, l, st, ab);
    sb.push_back(mdl_vec());
    #1;
    cyc++;
    e = sb.pop_front();
    chk("sb", 32'(dut_vec()), 32'(e));
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (run_o) run_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic begin_seq(input int l);
    cyc = 0;
    done_cnt = 0;
    done_cyc = -1;
    run_cnt = 0;
    step(1, l, 0, 0);
  endtask

  task automatic async_rst(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk(tag, 32'(dut_vec()), 32'd0);
    m_state = 0;
    m_cnt = 0;
    m_len = 0;
    m_err = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_state = 0;
    m_cnt = 0;
    m_len = 0;
    m_err = 0;
    rst_n = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    stall_i = 1'b0;
    abort_i = 1'b0;
    #3;
    chk("rst0", 32'(dut_vec()), 32'd0);
    #4;
    rst_n = 1'b1;
    idle(2);

    // nominal len 5
    begin_seq(5);
    chk("load1", 32'(state_o), 32'd1);
    idle(17);
    chk("done_cyc", done_cyc, 17);
    chk("done_n", done_cnt, 1);
    chk("run_n", run_cnt, 5);
    chk("idle18", 32'(state_o), 32'd0);

    // stall in RUN cycles 6-8
    begin_seq(5);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, cyc >= 6 && cyc <= 8, 0);
      if (cyc == 8) chk("stall_cnt", 32'(cnt_o), 32'd1);
    end
    chk("stall_done", done_cyc, 20);
    chk("stall_run", run_cnt, 8);

    // abort in DRAIN at cnt 3
    begin_seq(2);
    for (int i = 0; i < 40; i++) begin
      if (m_state == 3 && m_cnt == 3) break;
      step(0, 0, 0, 0);
    end
    chk("at_drain3", 32'(cnt_o), 32'd3);
    step(0, 0, 1, 1);
    chk("abort_st", 32'(state_o), 32'd0);
    chk("abort_cnt", 32'(cnt_o), 32'd0);
    step(1, 3, 0, 0);
    chk("restart", 32'(state_o), 32'd1);
    idle(20);
    chk("abort_done", done_cnt, 1);

    // illegal lengths and ignored start
    step(1, 0, 0, 0);
    chk("err0", 32'(err_o), 32'd1);
    step(0, 0, 0, 0);
    chk("err0_off", 32'(err_o), 32'd0);
    step(1, 65, 0, 0);
    chk("err65", 32'(err_o), 32'd1);
    chk("err65_st", 32'(state_o), 32'd0);
    begin_seq(3);
    idle(4);
    step(1, 9, 0, 0);
    chk("ign_err", 32'(err_o), 32'd0);
    idle(16);
    chk("ign_done", done_cyc, 15);

    // abort with start in IDLE starts
    step(1, 2, 1, 1);
    chk("ab_start", 32'(state_o), 32'd1);
    idle(16);

    // max length, no wrap
    begin_seq(64);
    for (int i = 0; i < 67; i++) step(0, 0, 0, 0);
    chk("max_cnt", 32'(cnt_o), 32'd63);
    step(0, 0, 0, 0);
    chk("drain0_st", 32'(state_o), 32'd3);
    chk("drain0_cnt", 32'(cnt_o), 32'd0);
    idle(10);
    chk("max_done", done_cyc, 76);

    // reset during RUN
    begin_seq(64);
    idle(20);
    async_rst("rst_run");
    idle(80);
    chk("rst_nodone", done_cnt, 0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 70),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 29) == 0);
      if (i == 250) async_rst("rst_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
